// File: rtl/btn_pkg.sv
// Shared types and constants for the button state reader.
package btn_pkg;

    localparam int N_BTN_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } deb_state_t;

endpackage

// File: rtl/btn_state_reader_if.sv
// Button-side bus: raw levels in, debounced state, edge pulses and sticky press events out.
interface btn_state_reader_if #(
    parameter int N_BTN = btn_pkg::N_BTN_DEFAULT
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] state_out;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] evt_press;
    logic             evt_valid;
    logic             evt_ack;

    modport master (
        output btn_in,
        output evt_ack,
        input  state_out,
        input  press_pulse,
        input  release_pulse,
        input  evt_press,
        input  evt_valid
    );

    modport slave (
        input  btn_in,
        input  evt_ack,
        output state_out,
        output press_pulse,
        output release_pulse,
        output evt_press,
        output evt_valid
    );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, four-state debounce FSM with a
// confirmation counter, and registered press/release pulses.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic state,
    output logic press,
    output logic rel
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync0;
    logic             sync1;
    deb_state_t       st_q;
    deb_state_t       st_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             state_d;
    logic             press_d;
    logic             rel_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= btn_raw;
            sync1 <= sync0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= ST_LOW;
            cnt_q <= '0;
            state <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            state <= state_d;
            press <= press_d;
            rel   <= rel_d;
        end
    end

    // The first opposite sample counts as 1, so acceptance lands on CNT_LAST.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        state_d = state;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (st_q)
            ST_LOW: begin
                if (sync1) begin
                    st_d  = ST_RISE;
                    cnt_d = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_RISE: begin
                if (!sync1) begin
                    st_d  = ST_LOW;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    st_d    = ST_HIGH;
                    cnt_d   = '0;
                    state_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync1) begin
                    st_d  = ST_FALL;
                    cnt_d = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_FALL: begin
                if (sync1) begin
                    st_d  = ST_HIGH;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    st_d    = ST_LOW;
                    cnt_d   = '0;
                    state_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                st_d  = ST_LOW;
                cnt_d = '0;
            end
        endcase
    end
endmodule

// File: rtl/btn_state_reader.sv
// Debounced button state reader; define BTN_EVENT_LATCH_EN to build the
// sticky press-event register with its acknowledge handshake.
module btn_state_reader
    import btn_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    btn_state_reader_if.slave      bus
);
    logic [N_BTN-1:0] state_vec;
    logic [N_BTN-1:0] press_vec;
    logic [N_BTN-1:0] rel_vec;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(bus.btn_in[i]),
            .state  (state_vec[i]),
            .press  (press_vec[i]),
            .rel    (rel_vec[i])
        );
    end

    assign bus.state_out     = state_vec;
    assign bus.press_pulse   = press_vec;
    assign bus.release_pulse = rel_vec;

`ifdef BTN_EVENT_LATCH_EN
    logic [N_BTN-1:0] evt_q;

    // A press in the same cycle as an acknowledge survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_q <= '0;
        end else begin
            evt_q <= press_vec | (bus.evt_ack ? '0 : evt_q);
        end
    end

    assign bus.evt_press = evt_q;
    assign bus.evt_valid = |evt_q;
`else
    logic unused_evt_ack;

    assign unused_evt_ack = bus.evt_ack;
    assign bus.evt_press  = '0;
    assign bus.evt_valid  = 1'b0;
`endif
endmodule

// File: doc/btn_state_reader.md
# btn_state_reader

Input-side counterpart of the LED status path: samples four raw board push-buttons/switches, synchronises and debounces each one, and presents a clean 4-bit state word in the same format the LED driver consumes (bit i = channel i). It also emits single-cycle press/release pulses. An optional sticky press-event register with an acknowledge handshake lets the PS-side driver poll button activity. It sits between the board button pins and the control/state logic.

## Interface
- N_BTN, 4, number of button channels
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); minimum 2
- CNT_W, $clog2(DEBOUNCE_CYCLES), counter width (derived, not overridden)

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- btn_in  input  N_BTN  raw, asynchronous button levels, 1 = pressed
- state_out  output  N_BTN  debounced button state, same bit order as btn_in
- press_pulse  output  N_BTN  one-cycle high when the corresponding state_out bit goes 0->1
- release_pulse  output  N_BTN  one-cycle high when the corresponding state_out bit goes 1->0
- evt_press  output  N_BTN  sticky press flags (BTN_EVENT_LATCH_EN only, else 0)
- evt_valid  output  1  OR of evt_press
- evt_ack  input  1  clear request for evt_press (ignored when the feature is compiled out)

## Operation
- Each channel: 2-flop synchroniser (sync0, sync1), then a debounce FSM with a counter.
- FSM states: ST_LOW (stable 0), ST_RISE (confirming 1), ST_HIGH (stable 1), ST_FALL (confirming 0).
- ST_LOW: sync1=1 -> ST_RISE, cnt<=1; else stay, cnt<=0.
- ST_RISE: sync1=0 -> ST_LOW, cnt<=0 (glitch rejected); sync1=1 and cnt==DEBOUNCE_CYCLES-1 -> ST_HIGH, state bit<=1, press_pulse asserted; else cnt<=cnt+1.
- ST_HIGH / ST_FALL: mirror image; acceptance sets state bit<=0 and asserts release_pulse.
- The counter never exceeds DEBOUNCE_CYCLES-1 and has no wrap-around path.
- Channels are fully independent, so simultaneous changes on several channels produce simultaneous pulses.
- Sticky register (feature on): evt_press[i] is set by press_pulse[i]. evt_ack=1 clears every bit whose press_pulse is 0 in that cycle. When set and clear coincide, set wins. evt_ack held high clears continuously.
- Release events are not latched.

## Timing
- Reset values: sync flops 0, FSM ST_LOW, cnt 0, state_out 0, press_pulse 0, release_pulse 0, evt_press 0, evt_valid 0.
- Reset asserted mid-confirmation discards the pending change. After reset the block re-qualifies the current input from ST_LOW, so a button held through reset yields a press_pulse once qualified.
- Latency: if btn_in changes and stays stable, state_out changes exactly 2 + DEBOUNCE_CYCLES clock edges later.
- press_pulse/release_pulse are registered and high in the same cycle as the new state_out value.
- evt_press sets one cycle after press_pulse (registered from it). evt_valid is combinational from evt_press.
- Any opposite-level sample during confirmation restarts qualification. Pulses shorter than DEBOUNCE_CYCLES cycles never reach state_out.

## Configuration
- BTN_EVENT_LATCH_EN defined: the sticky evt_press register and evt_ack handshake are built.
- BTN_EVENT_LATCH_EN undefined: evt_press and evt_valid are tied to 0, evt_ack is unused, and no flops are inferred. The port list is unchanged.

## Structure
- Package btn_pkg: debounce state enum (ST_LOW, ST_RISE, ST_HIGH, ST_FALL) and the default N_BTN constant.
- Sub-module btn_debounce_ch: one channel (synchroniser, FSM, counter, pulses). It is instantiated N_BTN times via generate.
- Top level holds only the generate loop and the sticky register.

## Test plan
- DEBOUNCE_CYCLES=8, btn_in[0] 0->1 held -> state_out=4'b0001 and press_pulse[0] high for one cycle, exactly 10 edges after the change.
- btn_in[1] high for 5 cycles then low -> state_out stays 0 and no pulses.
- Bounce pattern 1,0,1,1,0 then stable 1 on btn_in[2] -> state_out[2]=1 exactly 10 edges after the final stable 1.
- All four buttons pressed in the same cycle -> press_pulse=4'b1111 in one cycle. Release all -> release_pulse=4'b1111 in one cycle.
- Feature on: press ch3 -> evt_press=4'b1000 and evt_valid=1. Pulse evt_ack -> evt_press=0. Ack coinciding with a ch0 press -> evt_press=4'b0001.
- Assert rst while ch0 is in ST_RISE at cnt=5 -> all outputs 0. Deassert with btn held -> press_pulse[0] after 10 edges.
